// File: rtl/issue_scheduler.sv
// Out-of-order issue queue with physical-register busy table.
// Collapsing age-ordered queue: index 0 is the oldest entry. Each cycle the
// oldest entry with both operands ready is presented; on issue the entries
// above it shift down one slot. Writebacks wake waiting operands and clear
// busy bits. A flush squashes the queue and releases squashed destinations.
module issue_scheduler #(
  parameter int DEPTH    = 16,
  parameter int NUM_PHYS = 64,
  parameter int PHYS_W   = 6,
  parameter int TAG_W    = 5,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_rs_used,
  input  logic              in_rt_used,
  input  logic              in_rd_used,
  input  logic [PHYS_W-1:0] in_rs_phys,
  input  logic [PHYS_W-1:0] in_rt_phys,
  input  logic [PHYS_W-1:0] in_rd_phys,
  input  logic              wb_valid,
  input  logic [PHYS_W-1:0] wb_phys,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  output logic [PHYS_W-1:0] issue_rs_phys,
  output logic [PHYS_W-1:0] issue_rt_phys,
  output logic [PHYS_W-1:0] issue_rd_phys,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [PHYS_W-1:0] rs;
    logic [PHYS_W-1:0] rt;
    logic [PHYS_W-1:0] rd;
    logic              rd_used;
    logic              rs_rdy;
    logic              rt_rdy;
  } entry_t;

  entry_t              ent_q [DEPTH];
  entry_t              ent_d [DEPTH];
  entry_t              woken [DEPTH+1];
  entry_t              new_ent;
  logic [NUM_PHYS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    app_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic                dispatch;
  logic                issue_fire;

  // An operand is ready if unused, phys 0, not busy, or written back this cycle.
  function automatic logic op_ready(input logic                used,
                                    input logic [PHYS_W-1:0]   p,
                                    input logic [NUM_PHYS-1:0] busy,
                                    input logic                wbv,
                                    input logic [PHYS_W-1:0]   wbp);
    return !used || (p == '0) || !busy[p] || (wbv && (wbp == p));
  endfunction

  assign in_ready   = (count_q < DEPTH_C) && !flush;
  assign dispatch   = in_valid && in_ready;
  assign issue_fire = sel_found && issue_ready && !flush;
  assign count      = count_q;

  // Oldest-ready select over registered state only.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && ent_q[i].valid && ent_q[i].rs_rdy && ent_q[i].rt_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_valid   = sel_found;
  assign issue_tag     = ent_q[sel_idx].tag;
  assign issue_rs_phys = ent_q[sel_idx].rs;
  assign issue_rt_phys = ent_q[sel_idx].rt;
  assign issue_rd_phys = ent_q[sel_idx].rd;

  // Queue next state: wakeup, collapse above the issued slot, then append.
  // Wakeup is applied before the shift so a moving entry keeps its wakeup;
  // the append slot is count-1 when an issue frees a slot in the same cycle.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.tag     = in_tag;
    new_ent.rs      = in_rs_phys;
    new_ent.rt      = in_rt_phys;
    new_ent.rd      = in_rd_phys;
    new_ent.rd_used = in_rd_used;
    new_ent.rs_rdy  = op_ready(in_rs_used, in_rs_phys, busy_q, wb_valid, wb_phys);
    new_ent.rt_rdy  = op_ready(in_rt_used, in_rt_phys, busy_q, wb_valid, wb_phys);

    for (int unsigned i = 0; i < DEPTH; i++) begin
      woken[i] = ent_q[i];
      if (wb_valid && ent_q[i].valid) begin
        if (ent_q[i].rs == wb_phys) woken[i].rs_rdy = 1'b1;
        if (ent_q[i].rt == wb_phys) woken[i].rt_rdy = 1'b1;
      end
    end
    woken[DEPTH] = '0;

    app_idx = count_q - CNT_W'(issue_fire);

    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue_fire && (IDX_W'(i) >= sel_idx)) ? woken[i+1] : woken[i];
      if (dispatch && (CNT_W'(i) == app_idx)) ent_d[i] = new_ent;
      if (flush) ent_d[i] = '0;
    end

    if (flush) count_d = '0;
    else       count_d = count_q + CNT_W'(dispatch) - CNT_W'(issue_fire);
  end

  // Busy table next state: writeback clears, dispatch set wins, flush releases squashed rd.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_phys] = 1'b0;
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && ent_q[i].rd_used) busy_d[ent_q[i].rd] = 1'b0;
      end
    end else if (dispatch && in_rd_used && (in_rd_phys != '0)) begin
      busy_d[in_rd_phys] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: stimulus pushes expected issues into a
// scoreboard queue; a negedge monitor pops and compares on every accepted issue.
module tb_issue_scheduler;

  localparam int DEPTH    = 16;
  localparam int NUM_PHYS = 64;
  localparam int PHYS_W   = 6;
  localparam int TAG_W    = 5;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic              in_rs_used, in_rt_used, in_rd_used;
  logic [PHYS_W-1:0] in_rs_phys, in_rt_phys, in_rd_phys;
  logic              wb_valid;
  logic [PHYS_W-1:0] wb_phys;
  logic              issue_valid;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_tag;
  logic [PHYS_W-1:0] issue_rs_phys, issue_rt_phys, issue_rd_phys;
  logic              flush;
  logic [CNT_W-1:0]  count;

  issue_scheduler #(
    .DEPTH(DEPTH), .NUM_PHYS(NUM_PHYS), .PHYS_W(PHYS_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_rs_used(in_rs_used), .in_rt_used(in_rt_used), .in_rd_used(in_rd_used),
    .in_rs_phys(in_rs_phys), .in_rt_phys(in_rt_phys), .in_rd_phys(in_rd_phys),
    .wb_valid(wb_valid), .wb_phys(wb_phys),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .issue_rs_phys(issue_rs_phys), .issue_rt_phys(issue_rt_phys),
    .issue_rd_phys(issue_rd_phys),
    .flush(flush), .count(count)
  );

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PHYS_W-1:0] rs;
    logic [PHYS_W-1:0] rt;
    logic [PHYS_W-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted issue must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (rst_n && issue_valid && issue_ready && !flush) begin
      n_cmp++;
      got = '{tag: issue_tag, rs: issue_rs_phys, rt: issue_rt_phys, rd: issue_rd_phys};
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got tag=%0d rs=%0d rt=%0d rd=%0d, expected no issue",
                 got.tag, got.rs, got.rt, got.rd);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL issue_fields: got tag=%0d rs=%0d rt=%0d rd=%0d, expected tag=%0d rs=%0d rt=%0d rd=%0d",
                   got.tag, got.rs, got.rt, got.rd, e.tag, e.rs, e.rt, e.rd);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int tag, input int rs, input int rt, input int rd);
    exp_t e;
    e.tag = TAG_W'(tag);
    e.rs  = PHYS_W'(rs);
    e.rt  = PHYS_W'(rt);
    e.rd  = PHYS_W'(rd);
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one dispatch request for exactly one clock edge.
  task automatic disp(input int tag, input bit rsu, input int rs, input bit rtu,
                      input int rt, input bit rdu, input int rd);
    in_valid   = 1'b1;
    in_tag     = TAG_W'(tag);
    in_rs_used = rsu;
    in_rs_phys = PHYS_W'(rs);
    in_rt_used = rtu;
    in_rt_phys = PHYS_W'(rt);
    in_rd_used = rdu;
    in_rd_phys = PHYS_W'(rd);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_tag = '0;
    in_rs_used = 1'b0; in_rt_used = 1'b0; in_rd_used = 1'b0;
    in_rs_phys = '0; in_rt_phys = '0; in_rd_phys = '0;
    wb_valid = 1'b0; wb_phys = '0; issue_ready = 1'b0; flush = 1'b0;

    #2;
    chk("reset_count", int'(count), 0);
    chk("reset_issue_valid", int'(issue_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    #10 rst_n = 1'b1;
    tick();

    // Basic dispatch -> issue with latency 1; rd 40 becomes busy.
    disp(3, 1, 5, 1, 6, 1, 40);
    chk("t1_issue_valid", int'(issue_valid), 1);
    chk("t1_issue_tag", int'(issue_tag), 3);
    chk("t1_issue_rd", int'(issue_rd_phys), 40);
    chk("t1_count", int'(count), 1);
    push(3, 5, 6, 40);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("t1_count_after", int'(count), 0);

    // Dependency through rd 40: B waits for writeback of 40.
    disp(4, 1, 7, 1, 8, 1, 40);
    disp(5, 1, 40, 1, 9, 1, 10);
    chk("t2_count", int'(count), 2);
    chk("t2_only_a_tag", int'(issue_tag), 4);
    push(4, 7, 8, 40);
    issue_ready = 1'b1;
    tick();
    chk("t2_b_blocked", int'(issue_valid), 0);
    wb_valid = 1'b1; wb_phys = 6'd40;
    #1;
    chk("t2_wake_not_same_cycle", int'(issue_valid), 0);
    tick();
    wb_valid = 1'b0;
    push(5, 40, 9, 10);
    chk("t2_b_valid", int'(issue_valid), 1);
    chk("t2_b_tag", int'(issue_tag), 5);
    tick();

    // Same-cycle writeback bypass at dispatch.
    push(6, 0, 0, 41);
    disp(6, 0, 0, 0, 0, 1, 41);
    tick();
    chk("t3_empty_before_d", int'(issue_valid), 0);
    push(7, 41, 0, 0);
    wb_valid = 1'b1; wb_phys = 6'd41;
    disp(7, 1, 41, 0, 0, 0, 0);
    wb_valid = 1'b0;
    chk("t3_bypass_valid", int'(issue_valid), 1);
    chk("t3_bypass_tag", int'(issue_tag), 7);
    tick();

    // Make 50 and 51 busy, then fill the queue with waiting entries.
    push(8, 0, 0, 50);
    disp(8, 0, 0, 0, 0, 1, 50);
    push(9, 0, 0, 51);
    disp(9, 0, 0, 0, 0, 1, 51);
    tick();
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(10 + i, 1, (i == 2 || i == 7) ? 51 : 50, 0, 0, 0, 0);
    end
    chk("t4_full_count", int'(count), 16);
    chk("t4_full_in_ready", int'(in_ready), 0);
    chk("t4_none_ready", int'(issue_valid), 0);
    disp(31, 0, 0, 0, 0, 0, 0);
    chk("t4_full_reject", int'(count), 16);
    push(12, 51, 0, 0);
    push(17, 51, 0, 0);
    issue_ready = 1'b1;
    wb_valid = 1'b1; wb_phys = 6'd51;
    tick();
    wb_valid = 1'b0;
    chk("t4_first_tag", int'(issue_tag), 12);
    tick();
    chk("t4_count_15", int'(count), 15);
    tick();
    chk("t4_count_14", int'(count), 14);
    chk("t4_rest_waiting", int'(issue_valid), 0);
    issue_ready = 1'b0;

    // Flush: clear queue, then squash five entries holding rd 42..46.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush1_count", int'(count), 0);
    for (int i = 0; i < 5; i++) disp(20 + i, 1, 50, 0, 0, 1, 42 + i);
    chk("t5_count5", int'(count), 5);
    flush = 1'b1;
    #1;
    chk("t5_flush_in_ready", int'(in_ready), 0);
    disp(30, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    chk("t5_flush_count", int'(count), 0);
    chk("t5_flush_issue_valid", int'(issue_valid), 0);
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1 + i, 42 + i, 0, 0);
      disp(1 + i, 1, 42 + i, 0, 0, 0, 0);
    end
    tick();
    chk("t5_busy_released", int'(count), 0);
    issue_ready = 1'b0;

    // Asynchronous reset with 8 entries queued.
    for (int i = 0; i < 8; i++) disp(i, 1, 50, 0, 0, 1, 53 + i);
    chk("t6_count8", int'(count), 8);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_count", int'(count), 0);
    chk("t6_async_issue_valid", int'(issue_valid), 0);
    chk("t6_async_in_ready", int'(in_ready), 1);
    #2 rst_n = 1'b1;
    tick();
    issue_ready = 1'b1;
    push(9, 50, 0, 0);
    disp(9, 1, 50, 0, 0, 0, 0);
    push(10, 53, 60, 0);
    disp(10, 1, 53, 1, 60, 0, 0);
    tick();
    tick();
    chk("t6_busy_cleared", int'(count), 0);
    issue_ready = 1'b0;

    tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Out-of-order issue queue and physical-register busy-bit scheduler; sits between the rename stage and the single execute/writeback pipe.
- Rename dispatches renamed instructions (physical rs/rt/rd plus an opaque payload tag). The block tracks operand readiness through a NUM_PHYS-entry busy table and wakes entries on writeback broadcasts.
- Each cycle it selects the oldest ready entry and issues it; mispredict flush squashes the whole queue.

Parameters:
- DEPTH, 16, queue entries.
- NUM_PHYS, 64, physical registers (busy-table size).
- PHYS_W, 6, physical register index width; clog2(NUM_PHYS).
- TAG_W, 5, width of the opaque payload tag (ROB/payload index).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  dispatch request.
- in_ready  out  1  queue can accept a dispatch this cycle.
- in_tag  in  TAG_W  payload tag.
- in_rs_used / in_rt_used / in_rd_used  in  1 each  operand/destination present.
- in_rs_phys / in_rt_phys / in_rd_phys  in  PHYS_W each  physical indices.
- wb_valid  in  1  writeback broadcast.
- wb_phys  in  PHYS_W  physical register written.
- issue_valid  out  1  a ready entry is presented.
- issue_ready  in  1  execute accepts.
- issue_tag  out  TAG_W  tag of selected entry.
- issue_rs_phys / issue_rt_phys / issue_rd_phys  out  PHYS_W each  operands of selected entry.
- flush  in  1  squash all queued entries.
- count  out  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, rst_n=0): all entries invalid, all busy bits 0, count=0, issue_valid=0, in_ready=1. Reset mid-operation discards everything immediately.
- Entry fields: valid, tag, rs/rt/rd phys, rd_used, rs_rdy, rt_rdy. Entries are kept age-ordered in a collapsing queue: index 0 is oldest, and new entries append at index count.
- Dispatch fires when in_valid && in_ready, with in_ready = (count < DEPTH) && !flush. Same-cycle issue frees no slot for dispatch, so a full queue stalls even when issuing.
- Operand ready capture at dispatch: rdy = !used || phys==0 || !busy[phys] || (wb_valid && wb_phys==phys). Same-cycle writeback bypass is required.
- Busy set: dispatch with in_rd_used and in_rd_phys!=0 sets busy[in_rd_phys] at the edge.
- Busy clear: wb_valid clears busy[wb_phys]. If set and clear hit the same index in one cycle, set wins. Phys reg 0 is never busy.
- Wakeup: wb_valid sets rs_rdy/rt_rdy in every valid entry whose matching phys equals wb_phys, registered. The entry becomes selectable the cycle after the writeback.
- Select: combinational over registered state; lowest-index valid entry with rs_rdy && rt_rdy. issue_valid=1 if any exists, and issue_* carry that entry's fields. issue_* are don't-care when issue_valid=0.
- A newly dispatched entry is selectable no earlier than the next cycle (latency 1 from dispatch to issue).
- Issue fires when issue_valid && issue_ready. At the edge the entry is removed, entries above it shift down one index (age order preserved), and count decrements.
- Simultaneous dispatch and issue: the shift and the append happen in the same cycle; the new entry lands at index count-1, and count is unchanged.
- issue_valid must not depend on issue_ready. issue_* remain stable while issue_valid && !issue_ready, unless a wakeup makes an older entry ready, in which case the older entry is presented instead.
- Flush (synchronous, highest priority): all entries invalidated and count=0 at the edge. busy bits for rd of every valid squashed entry are cleared. Dispatch and issue in the flush cycle are ignored. wb_valid is still applied to the busy table.
- count is the registered occupancy, range 0..DEPTH.

Test Plan:
- Reset, then dispatch tag=3 (rs=5, rt=6 both not busy, rd=40) -> issue_valid=1 next cycle with issue_tag=3, issue_rd_phys=40; busy[40]=1.
- Dispatch A (rd=40), then B (rs=40), with issue_ready=0 -> only A selectable. Raise issue_ready, then wb_valid with wb_phys=40 -> B issues the cycle after the writeback.
- Dispatch with rs=41 busy while wb_phys=41 arrives in the same cycle -> entry captured ready and issues next cycle.
- Fill 16 entries, all not ready -> in_ready=0 and count=16. Writeback wakes entries at index 2 and 7 -> index 2 issues first, index 7 issues next, count ends at 14.
- Queue holds 5 entries with rd 42..46, then flush -> count=0, issue_valid=0, busy[42..46]=0 the next cycle; a dispatch attempted during the flush cycle is not accepted.
- Assert rst_n=0 asynchronously with 8 entries queued -> count=0, issue_valid=0, in_ready=1 without waiting for a clock edge; all busy bits read 0.
